scratchpad_copy_engine: RTL
===========================

# scratchpad_copy_engine

Initiator-side engine for the scratchpad memory port. It accepts a copy command (source, destination, doubleword count) over a valid/ready handshake. It then drives the scratchpad's single-port `en`/`write`/`addr`/`len`/`wdata`/`rdata` interface to copy the region one 64-bit doubleword at a time, and signals completion or a range error. It sits between a host command source and the scratchpad, and is the only master of the scratchpad port while busy.

## Interface
- `SCRATCHPAD_BASE`, default 64'h0300_0000_0000_0000: base address of the scratchpad.
- `SCRATCHPAD_SIZE`, default 524288: scratchpad size in bytes (512 B × 1024 chunks).
- `COUNT_WIDTH`, default 16: width of the doubleword count.
- `clk` in 1: clock; all logic is on posedge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine can accept a command.
- `cmd_src` in 64: source byte address.
- `cmd_dst` in 64: destination byte address.
- `cmd_count` in COUNT_WIDTH: number of doublewords to copy.
- `busy` out 1: command in progress (state ≠ IDLE).
- `done` out 1: one-cycle completion pulse.
- `error` out 1: status of the last command; valid from `done` until the next accept.
- `mem_en` out 1: scratchpad access enable.
- `mem_write` out 1: 1 = write, 0 = read.
- `mem_addr` out 64: absolute scratchpad address.
- `mem_len` out 2: access length; always 2'b11 (double).
- `mem_wdata` out 64: write data.
- `mem_rdata` in 64: scratchpad read data, valid the cycle after a read is issued.

## Operation
- States: IDLE, CHECK, READ, CAPTURE, WRITE, DONE.
- IDLE: `cmd_ready`=1. When `cmd_valid`&&`cmd_ready`, the engine latches src, dst and count, clears `error`, and moves to CHECK.
- CHECK validates the command through a 65-bit computation, `end = addr + 8*count`, applied to both src and dst. The command is legal only if all of the following hold:
  - `addr[2:0]`==0;
  - `addr` >= BASE;
  - `end` <= BASE+SIZE;
  - no 64-bit wrap occurs.
- CHECK outcomes:
  - Illegal: set `error`=1 and go to DONE. No memory access is made.
  - Count==0: go to DONE with `error`=0. No memory access is made.
  - Otherwise: go to READ with index i=0.
- READ: `mem_en`=1, `mem_write`=0, `mem_addr`=src+8i.
- CAPTURE: `mem_en`=0; `mem_rdata` is latched into the data buffer.
- WRITE: `mem_en`=1, `mem_write`=1, `mem_addr`=dst+8i, `mem_wdata`=buffer. Then i increments.
  - If i==count after the increment, go to DONE; otherwise go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Copy order is ascending and there is no overlap correction. When dst>src and the regions overlap, the source data propagates forward; this is defined behaviour.
- `mem_en`=0 in IDLE, CHECK, CAPTURE and DONE.

## Timing
- Reset values:
  - `mem_en`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `mem_len`=2'b11;
  - `done`=0, `error`=0, `busy`=0.
  - `cmd_ready`=1 from the first cycle after `reset` deasserts.
- Commands presented while `reset`=1 are ignored.
- All outputs are registered or decoded from state only; there is no combinational path from `cmd_*` or `mem_rdata` to any output.
- Cycle timing, with the accept cycle as cycle 0:
  - CHECK in cycle 1.
  - Word i: READ in cycle 2+3i, CAPTURE in 3+3i, WRITE in 4+3i.
  - `done` in cycle 2+3·count; for count=0 or an error, `done` is in cycle 2.
- Throughput: one doubleword per 3 cycles. The next command can be accepted in the cycle after `done`.
- `cmd_ready`=0 from cycle 1 through the DONE cycle inclusive. `cmd_valid` held high during that time is not consumed.
- Reset mid-command: on the next edge the engine returns to IDLE with `mem_en`=0, and `done` is not pulsed. Words already written stay written.
- count at its maximum (2^COUNT_WIDTH−1): the index counter is COUNT_WIDTH bits and its terminal compare must not wrap.

## Structure
- Package `scratchpad_pkg` holds:
  - the state enum;
  - `LEN_BYTE`/`LEN_HALF`/`LEN_WORD`/`LEN_DOUBLE` (2'b00..2'b11);
  - the default base and size constants, shared with the scratchpad.
- Sub-module `scratchpad_range_check`: combinational; inputs `addr` and `count`, output `legal`. It is instantiated twice, once for src and once for dst.

## Test plan
- **Basic copy:** preload src=BASE+0x100 with 0x11..,0x22..,0x33..; command dst=BASE+0x800, count=3. Required: `done` at cycle 11, the three dst words match, `error`=0, and exactly 6 accesses with `mem_len`=2'b11.
- **count=0:** `done` at cycle 2, `error`=0, no `mem_en` pulses.
- **Range errors:** each of the following must give `done` at cycle 2 with `error`=1 and no accesses:
  - src=BASE+0x4 (misaligned);
  - dst=BASE+SIZE−8 with count=2 (overrun);
  - src=BASE−8 (below base);
  - src=64'hFFFF_FFFF_FFFF_FFF8 with count=2 (wrap).
- **Overlap:** src words 1,2,3,4,5 at BASE; dst=BASE+8, count=4. Required: memory reads 1,1,1,1,1.
- **Backpressure and back-to-back:** hold `cmd_valid` high with two commands queued. Required: the second is accepted exactly one cycle after the first `done`, and `cmd_ready` is never high while `busy`.
- **Mid-operation reset:** assert `reset` in cycle 6 of a count=4 copy. Required: `mem_en`=0 on the next cycle, no `done`, dst word 0 written, dst words 2..3 unchanged, and a new command is accepted afterwards.

Source files
------------

// File: rtl/scratchpad_pkg.sv
// Shared types and constants for the scratchpad port and its copy engine.
package scratchpad_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_READ, ST_CAPTURE, ST_WRITE, ST_DONE
  } state_t;

  localparam logic [1:0] LEN_BYTE   = 2'b00;
  localparam logic [1:0] LEN_HALF   = 2'b01;
  localparam logic [1:0] LEN_WORD   = 2'b10;
  localparam logic [1:0] LEN_DOUBLE = 2'b11;

  localparam logic [63:0] SCRATCHPAD_BASE_DEF = 64'h0300_0000_0000_0000;
  localparam int unsigned SCRATCHPAD_SIZE_DEF = 524288;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
  } copy_ptrs_t;
endpackage

// File: rtl/scratchpad_range_check.sv
// Combinational legality test of one region [addr, addr+8*count) against the scratchpad window.
module scratchpad_range_check
  import scratchpad_pkg::*;
#(
  parameter logic [63:0] BASE        = SCRATCHPAD_BASE_DEF,
  parameter int unsigned SIZE        = SCRATCHPAD_SIZE_DEF,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic [63:0]            addr,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   legal
);
  logic [64:0] end_addr;
  logic [64:0] limit;

  // 65-bit sum so a region running past 2^64 shows up in bit 64
  assign end_addr = {1'b0, addr} + {{(62-COUNT_WIDTH){1'b0}}, count, 3'b000};
  assign limit    = {1'b0, BASE} + 65'(SIZE);
  assign legal    = (addr[2:0] == 3'b000) && (addr >= BASE) &&
                    (end_addr <= limit) && !end_addr[64];
endmodule

// File: rtl/scratchpad_copy_engine.sv
// Copies a doubleword region inside the scratchpad via its single-port interface, READ/CAPTURE/WRITE per word.
module scratchpad_copy_engine
  import scratchpad_pkg::*;
#(
  parameter logic [63:0] SCRATCHPAD_BASE = SCRATCHPAD_BASE_DEF,
  parameter int unsigned SCRATCHPAD_SIZE = SCRATCHPAD_SIZE_DEF,
  parameter int          COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [63:0]            cmd_src,
  input  logic [63:0]            cmd_dst,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   mem_en,
  output logic                   mem_write,
  output logic [63:0]            mem_addr,
  output logic [1:0]             mem_len,
  output logic [63:0]            mem_wdata,
  input  logic [63:0]            mem_rdata
);
  state_t                 state, nxt;
  copy_ptrs_t             ptr;
  logic [COUNT_WIDTH-1:0] cnt, idx;
  logic [63:0]            addr_q, wbuf;
  logic                   err_q, src_ok, dst_ok, last;

  scratchpad_range_check #(.BASE(SCRATCHPAD_BASE), .SIZE(SCRATCHPAD_SIZE), .COUNT_WIDTH(COUNT_WIDTH))
    u_src_chk (.addr(ptr.src), .count(cnt), .legal(src_ok));
  scratchpad_range_check #(.BASE(SCRATCHPAD_BASE), .SIZE(SCRATCHPAD_SIZE), .COUNT_WIDTH(COUNT_WIDTH))
    u_dst_chk (.addr(ptr.dst), .count(cnt), .legal(dst_ok));

  // one bit wider so count = 2^COUNT_WIDTH-1 terminates without wrapping
  assign last = ({1'b0, idx} + {{COUNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, cnt};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (cmd_valid) nxt = ST_CHECK;
      ST_CHECK:   nxt = (!(src_ok && dst_ok) || cnt == '0) ? ST_DONE : ST_READ;
      ST_READ:    nxt = ST_CAPTURE;
      ST_CAPTURE: nxt = ST_WRITE;
      ST_WRITE:   nxt = last ? ST_DONE : ST_READ;
      ST_DONE:    nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      cnt    <= '0;
      idx    <= '0;
      addr_q <= '0;
      wbuf   <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          ptr.src <= cmd_src;
          ptr.dst <= cmd_dst;
          cnt     <= cmd_count;
          idx     <= '0;
          err_q   <= 1'b0;
        end
        ST_CHECK: begin
          if (!(src_ok && dst_ok)) err_q <= 1'b1;
          else if (cnt != '0)      addr_q <= ptr.src;
        end
        ST_CAPTURE: begin
          wbuf   <= mem_rdata;
          addr_q <= ptr.dst;
        end
        ST_WRITE: begin
          idx     <= idx + 1'b1;
          ptr.src <= ptr.src + 64'd8;
          ptr.dst <= ptr.dst + 64'd8;
          addr_q  <= ptr.src + 64'd8;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign error     = err_q;
  assign mem_en    = (state == ST_READ) || (state == ST_WRITE);
  assign mem_write = (state == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_len   = LEN_DOUBLE;
  assign mem_wdata = wbuf;
endmodule
